// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Game sequencer for the VGA pong demo. Owns the game state register, both
// player scores, the serve hold-off counter and the ball datapath strobes.
//
// Ports:
//   board_clk   system clock
//   reset       asynchronous, active-high reset
//   start       game-enable level (synchronous)
//   frame_tick  one pulse per video frame
//   miss_left   ball passed P1's (left) paddle
//   miss_right  ball passed P2's (right) paddle
//   state       00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE
//   p1_score    P1 points
//   p2_score    P2 points
//   ball_run    ball datapath enable (also marks the RUN phase of a game state)
//   ball_load   one-cycle pulse to recentre the ball
//   serve_dir   0 = launch rightward, 1 = launch leftward
//   winner      00 none, 01 P1, 10 P2
//
// state   | meaning
// QI      | idle, scores held at zero, waiting for a start rise
// QGAME_1 | rally in play, P1 serves (HOLD while ball_run=0, RUN while 1)
// QGAME_2 | rally in play, P2 serves
// QDONE   | a player reached WIN_SCORE; everything frozen until start drops
module pong_game_ctrl #(
    parameter logic [3:0] WIN_SCORE    = 4'd10,
    parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_run,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic       ball_run_q, ball_run_d;
    logic       ball_load_q, ball_load_d;
    logic       serve_dir_q, serve_dir_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       start_q, start_d;

    logic [3:0] p1_inc;
    logic [3:0] p2_inc;

    assign p1_inc = p1_score_q + 4'd1;
    assign p2_inc = p2_score_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        ball_run_d  = ball_run_q;
        ball_load_d = 1'b0;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        hold_cnt_d  = hold_cnt_q;
        start_d     = start;

        case (state_q)
            QI: begin
                p1_score_d = 4'd0;
                p2_score_d = 4'd0;
                winner_d   = 2'b00;
                ball_run_d = 1'b0;
                if (start && !start_q) begin
                    state_d     = QGAME_1;
                    ball_load_d = 1'b1;
                    hold_cnt_d  = SERVE_FRAMES;
                    serve_dir_d = 1'b0;
                end
            end

            QGAME_1, QGAME_2: begin
                if (!start) begin
                    // Abort outranks any miss or tick in the same cycle.
                    state_d     = QI;
                    p1_score_d  = 4'd0;
                    p2_score_d  = 4'd0;
                    winner_d    = 2'b00;
                    ball_run_d  = 1'b0;
                    serve_dir_d = 1'b0;
                end else if (!ball_run_q) begin
                    // HOLD: misses are ignored, only the serve timer runs.
                    if (hold_cnt_q == 8'd0) begin
                        ball_run_d = 1'b1;
                    end else if (frame_tick && hold_cnt_q == 8'd1) begin
                        ball_run_d = 1'b1;
                        hold_cnt_d = 8'd0;
                    end else if (frame_tick) begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end
                end else if (miss_left && miss_right) begin
                    // Simultaneous misses: replay the rally from the same server.
                    ball_run_d  = 1'b0;
                    ball_load_d = 1'b1;
                    hold_cnt_d  = SERVE_FRAMES;
                end else if (miss_left) begin
                    p2_score_d  = p2_inc;
                    ball_run_d  = 1'b0;
                    ball_load_d = 1'b1;
                    if (p2_inc == WIN_SCORE) begin
                        state_d  = QDONE;
                        winner_d = 2'b10;
                    end else begin
                        state_d     = QGAME_1;
                        hold_cnt_d  = SERVE_FRAMES;
                        serve_dir_d = 1'b0;
                    end
                end else if (miss_right) begin
                    p1_score_d  = p1_inc;
                    ball_run_d  = 1'b0;
                    ball_load_d = 1'b1;
                    if (p1_inc == WIN_SCORE) begin
                        state_d  = QDONE;
                        winner_d = 2'b01;
                    end else begin
                        state_d     = QGAME_2;
                        hold_cnt_d  = SERVE_FRAMES;
                        serve_dir_d = 1'b1;
                    end
                end
            end

            QDONE: begin
                ball_run_d = 1'b0;
                if (!start) begin
                    state_d     = QI;
                    p1_score_d  = 4'd0;
                    p2_score_d  = 4'd0;
                    winner_d    = 2'b00;
                    serve_dir_d = 1'b0;
                end
            end

            default: begin
                state_d = QI;
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q     <= QI;
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            ball_run_q  <= 1'b0;
            ball_load_q <= 1'b0;
            serve_dir_q <= 1'b0;
            winner_q    <= 2'b00;
            hold_cnt_q  <= 8'd0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            ball_run_q  <= ball_run_d;
            ball_load_q <= ball_load_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            hold_cnt_q  <= hold_cnt_d;
            start_q     <= start_d;
        end
    end

    assign state     = state_q;
    assign p1_score  = p1_score_q;
    assign p2_score  = p2_score_q;
    assign ball_run  = ball_run_q;
    assign ball_load = ball_load_q;
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
// Scoreboard bench for pong_game_ctrl with SERVE_FRAMES=3, WIN_SCORE=10.
// Each stimulus cycle pushes the outputs expected after its clock edge; they
// are popped and compared 1 ns after that edge.
module tb_pong_game_ctrl;

    localparam logic [3:0] WIN = 4'd10;
    localparam logic [7:0] SF  = 8'd3;

    typedef struct packed {
        logic [1:0] state;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       run;
        logic       load;
        logic       dir;
        logic [1:0] winner;
    } exp_t;

    logic       board_clk = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_left  = 1'b0;
    logic       miss_right = 1'b0;
    logic [1:0] state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       ball_run;
    logic       ball_load;
    logic       serve_dir;
    logic [1:0] winner;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t e;

    pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .start     (start),
        .frame_tick(frame_tick),
        .miss_left (miss_left),
        .miss_right(miss_right),
        .state     (state),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .ball_run  (ball_run),
        .ball_load (ball_load),
        .serve_dir (serve_dir),
        .winner    (winner)
    );

    always #5 board_clk = ~board_clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 8'd1, 8'd0);
            return;
        end
        x = exp_q.pop_front();
        check_val({tag, ".state"},  {6'd0, state},     {6'd0, x.state});
        check_val({tag, ".p1"},     {4'd0, p1_score},  {4'd0, x.p1});
        check_val({tag, ".p2"},     {4'd0, p2_score},  {4'd0, x.p2});
        check_val({tag, ".run"},    {7'd0, ball_run},  {7'd0, x.run});
        check_val({tag, ".load"},   {7'd0, ball_load}, {7'd0, x.load});
        check_val({tag, ".dir"},    {7'd0, serve_dir}, {7'd0, x.dir});
        check_val({tag, ".winner"}, {6'd0, winner},    {6'd0, x.winner});
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, compare.
    task automatic step(input string tag, input logic st, input logic tk,
                        input logic ml, input logic mr, input exp_t x);
        start      = st;
        frame_tick = tk;
        miss_left  = ml;
        miss_right = mr;
        exp_q.push_back(x);
        @(posedge board_clk);
        #1;
        compare_out(tag);
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    // Three frame ticks from a fresh HOLD: ball_run rises only after the third.
    task automatic serve(input string tag);
        e.load = 1'b0;
        e.run  = 1'b0;
        step({tag, ".t1"}, 1'b1, 1'b1, 1'b0, 1'b0, e);
        step({tag, ".t2"}, 1'b1, 1'b1, 1'b0, 1'b0, e);
        e.run = 1'b1;
        step({tag, ".t3"}, 1'b1, 1'b1, 1'b0, 1'b0, e);
    endtask

    initial begin
        e = '0;
        #2;
        exp_q.push_back(e);
        compare_out("reset");
        #10;
        reset = 1'b0;
        @(negedge board_clk);

        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, e);

        // Start rise: QGAME_1, load pulse, hold-off of 3 ticks.
        e.state = 2'b01; e.load = 1'b1;
        step("rise", 1'b1, 1'b0, 1'b0, 1'b0, e);
        e.load = 1'b0;
        step("hold_notick", 1'b1, 1'b0, 1'b0, 1'b0, e);
        serve("serve0");

        // miss_right in RUN: P1 scores, P2 serves.
        e.p1 = 4'd1; e.state = 2'b10; e.dir = 1'b1; e.run = 1'b0; e.load = 1'b1;
        step("miss_r", 1'b1, 1'b0, 1'b0, 1'b1, e);
        serve("serve1");

        // Ten misses on the left: P2 wins.
        for (int i = 1; i <= 10; i++) begin
            e.p2   = 4'(i);
            e.run  = 1'b0;
            e.load = 1'b1;
            e.dir  = (i == 10) ? e.dir : 1'b0;
            e.state  = (i == 10) ? 2'b11 : 2'b01;
            e.winner = (i == 10) ? 2'b10 : 2'b00;
            step($sformatf("miss_l%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, e);
            if (i < 10) serve($sformatf("serve_l%0d", i));
        end
        e.load = 1'b0;
        step("done_frz1", 1'b1, 1'b1, 1'b1, 1'b1, e);
        step("done_frz2", 1'b1, 1'b1, 1'b0, 1'b1, e);
        e = '0;
        step("done_exit", 1'b0, 1'b0, 1'b0, 1'b0, e);

        // Restart, then a simultaneous miss replays with a reloaded hold-off.
        e.state = 2'b01; e.load = 1'b1;
        step("rise2", 1'b1, 1'b0, 1'b0, 1'b0, e);
        serve("serve2");
        e.run = 1'b0; e.load = 1'b1;
        step("replay", 1'b1, 1'b1, 1'b1, 1'b1, e);
        e.load = 1'b0;
        step("hold_ml", 1'b1, 1'b0, 1'b1, 1'b0, e);
        step("hold_mr", 1'b1, 1'b0, 1'b0, 1'b1, e);
        serve("serve3");

        // Build P1 up to 5, then abort mid-RUN.
        for (int i = 1; i <= 5; i++) begin
            e.p1 = 4'(i); e.state = 2'b10; e.dir = 1'b1; e.run = 1'b0; e.load = 1'b1;
            step($sformatf("miss_r%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, e);
            serve($sformatf("serve_r%0d", i));
        end
        e = '0;
        step("abort", 1'b0, 1'b0, 1'b1, 1'b0, e);
        e.state = 2'b01; e.load = 1'b1;
        step("rise3", 1'b1, 1'b0, 1'b0, 1'b0, e);
        e.load = 1'b0;
        step("tick_to2", 1'b1, 1'b1, 1'b0, 1'b0, e);

        // Async reset mid-HOLD (hold_cnt=2), checked without a clock edge.
        reset = 1'b1;
        #2;
        e = '0;
        exp_q.push_back(e);
        compare_out("async_rst");
        reset = 1'b0;
        // start is still high; start_q was cleared, so this counts as a rise.
        e.state = 2'b01; e.load = 1'b1;
        step("rst_rise", 1'b1, 1'b0, 1'b0, 1'b0, e);
        e.load = 1'b0;
        step("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, e);

        check_val("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
